// File: rtl/spi_shift_receiver_if.sv
// -----------------------------------------------------------------------------
// spi_shift_receiver_if
//   Bundles the serial pins and the word-level handshake of spi_shift_receiver.
//
//   Serial side : sclk_in, cs_n_in, mosi_in (driven by the SPI master, async to
//                 the receiver clock), miso_out (driven by the receiver).
//   Word side   : data_out / data_valid_out / data_ack_in (received words),
//                 tx_data_in / tx_load_out (word to transmit and its capture pulse),
//                 overrun_out / frame_err_out (single-cycle status pulses).
//
//   Modports:
//     slave  - the receiver itself (spi_shift_receiver)
//     master - the environment: SPI master plus word consumer/producer
// -----------------------------------------------------------------------------
interface spi_shift_receiver_if #(
    parameter int unsigned WIDTH = 8
);
    logic             sclk_in;
    logic             cs_n_in;
    logic             mosi_in;
    logic             miso_out;
    logic [WIDTH-1:0] data_out;
    logic             data_valid_out;
    logic             data_ack_in;
    logic [WIDTH-1:0] tx_data_in;
    logic             tx_load_out;
    logic             overrun_out;
    logic             frame_err_out;

    modport slave (
        input  sclk_in,
        input  cs_n_in,
        input  mosi_in,
        output miso_out,
        output data_out,
        output data_valid_out,
        input  data_ack_in,
        input  tx_data_in,
        output tx_load_out,
        output overrun_out,
        output frame_err_out
    );

    modport master (
        output sclk_in,
        output cs_n_in,
        output mosi_in,
        input  miso_out,
        input  data_out,
        input  data_valid_out,
        output data_ack_in,
        output tx_data_in,
        input  tx_load_out,
        input  overrun_out,
        input  frame_err_out
    );
endinterface

// File: rtl/spi_shift_receiver.sv
// -----------------------------------------------------------------------------
// spi_shift_receiver
//   Mode-0 (CPOL=0, CPHA=0) SPI target running entirely in the clk_in domain.
//   sclk/cs_n/mosi are oversampled through synchroniser chains; received words
//   (MSB first) are presented on a valid/ack port, and tx_data_in is shifted
//   out MSB first on miso_out. The serial clock must stay high and low for at
//   least two clk_in periods each.
//
//   Ports:
//     clk_in      - system clock, all state on posedge
//     reset_n_in  - asynchronous active-low reset
//     bus (slave) - serial pins, received-word handshake, transmit word,
//                   tx_load / overrun / frame_err pulses
//
//   Parameters:
//     WIDTH       - bits per word (>= 2)
//     SYNC_STAGES - synchroniser depth on sclk, cs_n and mosi (>= 2)
// -----------------------------------------------------------------------------
module spi_shift_receiver #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk_in,
    input  logic              reset_n_in,
    spi_shift_receiver_if.slave bus
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StActive = 1'b1
    } state_e;

    // -------------------------------------------------------------------------
    // Input synchronisers
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] cs_n_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic                   sclk_prev_q;

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            sclk_sync_q <= '0;
            cs_n_sync_q <= '1;   // deselected until proven otherwise
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk_in};
            cs_n_sync_q <= {cs_n_sync_q[SYNC_STAGES-2:0], bus.cs_n_in};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi_in};
            sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
        end
    end

    logic sclk_s;
    logic cs_n_s;
    logic mosi_s;
    logic sclk_rise;
    logic sclk_fall;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
    // mosi has the same chain depth as sclk, so mosi_s is the value that was on
    // the pin when the synchronised rising edge left the pin.
    assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;

    // -------------------------------------------------------------------------
    // Framing FSM and datapath
    // -------------------------------------------------------------------------
    state_e            state_q;
    logic [CntW-1:0]   bit_cnt_q;
    logic [WIDTH-1:0]  rx_shift_q;
    logic [WIDTH-1:0]  tx_shift_q;
    logic              word_done_q;   // last rising edge completed a word
    logic [WIDTH-1:0]  data_q;
    logic              data_valid_q;
    logic              tx_load_q;
    logic              overrun_q;
    logic              frame_err_q;

    logic [WIDTH-1:0]  rx_word;
    assign rx_word = {rx_shift_q[WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            state_q      <= StIdle;
            bit_cnt_q    <= '0;
            rx_shift_q   <= '0;
            tx_shift_q   <= '0;
            word_done_q  <= 1'b0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            tx_load_q    <= 1'b0;
            overrun_q    <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            tx_load_q   <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;

            // Consumer handshake; a word landing this cycle overrides below.
            if (data_valid_q && bus.data_ack_in) begin
                data_valid_q <= 1'b0;
            end

            case (state_q)
                StIdle: begin
                    bit_cnt_q   <= '0;
                    word_done_q <= 1'b0;
                    // IDLE is only re-entered with cs_n_s high, so a low level
                    // here always follows a falling edge.
                    if (!cs_n_s) begin
                        tx_shift_q <= bus.tx_data_in;
                        tx_load_q  <= 1'b1;
                        state_q    <= StActive;
                    end
                end

                StActive: begin
                    if (cs_n_s) begin
                        // Deselect wins over any coincident sclk edge.
                        state_q     <= StIdle;
                        bit_cnt_q   <= '0;
                        word_done_q <= 1'b0;
                        frame_err_q <= (bit_cnt_q != '0);
                    end else if (sclk_rise) begin
                        rx_shift_q <= rx_word;
                        if (bit_cnt_q == LastBit) begin
                            bit_cnt_q   <= '0;
                            word_done_q <= 1'b1;
                            if (!data_valid_q || bus.data_ack_in) begin
                                data_q       <= rx_word;
                                data_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + CntW'(1);
                        end
                    end else if (sclk_fall) begin
                        word_done_q <= 1'b0;
                        if (word_done_q) begin
                            // Present the next word's MSB before its first rise.
                            tx_shift_q <= bus.tx_data_in;
                            tx_load_q  <= 1'b1;
                        end else begin
                            tx_shift_q <= {tx_shift_q[WIDTH-2:0], 1'b0};
                        end
                    end
                end

                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign bus.miso_out       = (state_q == StActive) & tx_shift_q[WIDTH-1];
    assign bus.data_out       = data_q;
    assign bus.data_valid_out = data_valid_q;
    assign bus.tx_load_out    = tx_load_q;
    assign bus.overrun_out    = overrun_q;
    assign bus.frame_err_out  = frame_err_q;

endmodule

// File: tb/tb_spi_shift_receiver.sv
// -----------------------------------------------------------------------------
// tb_spi_shift_receiver
//   Directed bench for spi_shift_receiver: the bench plays SPI master with an
//   sclk period of 8 clk_in cycles (4 low, 4 high) and acts as word consumer.
// -----------------------------------------------------------------------------
module tb_spi_shift_receiver;

    logic clk_in     = 1'b0;
    logic reset_n_in = 1'b1;

    int checks   = 0;
    int failures = 0;

    int tx_load_cnt   = 0;
    int overrun_cnt   = 0;
    int frame_err_cnt = 0;

    spi_shift_receiver_if #(.WIDTH(8)) bus ();

    spi_shift_receiver #(
        .WIDTH       (8),
        .SYNC_STAGES (2)
    ) dut (
        .clk_in     (clk_in),
        .reset_n_in (reset_n_in),
        .bus        (bus)
    );

    always #5 clk_in = ~clk_in;

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk_in) begin
        if (bus.tx_load_out === 1'b1)   tx_load_cnt++;
        if (bus.overrun_out === 1'b1)   overrun_cnt++;
        if (bus.frame_err_out === 1'b1) frame_err_cnt++;
    end

    // -------------------------------------------------------------------------
    // Master helpers
    // -------------------------------------------------------------------------
    // Low phase with mosi set, then raise sclk. miso is sampled just before the
    // rising edge, which is where a mode-0 master samples it.
    task automatic sclk_bit(input logic b, output logic m);
        bus.mosi_in = b;
        repeat (4) @(negedge clk_in);
        m = bus.miso_out;
        bus.sclk_in = 1'b1;
    endtask

    // Shift the top n bits of word MSB first. With last_fall=0 sclk is left
    // high after the final bit.
    task automatic shift_bits(input logic [7:0] word, input int n, input bit last_fall,
                              output logic [7:0] m);
        logic mb;
        m = '0;
        for (int i = 0; i < n; i++) begin
            sclk_bit(word[7-i], mb);
            m = {m[6:0], mb};
            repeat (4) @(negedge clk_in);
            if (i < n - 1 || last_fall) bus.sclk_in = 1'b0;
        end
    endtask

    task automatic start_frame();
        bus.cs_n_in = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic end_frame();
        bus.cs_n_in = 1'b1;
        repeat (4) @(negedge clk_in);
    endtask

    task automatic ack_word();
        bus.data_ack_in = 1'b1;
        @(negedge clk_in);
        bus.data_ack_in = 1'b0;
    endtask

    // -------------------------------------------------------------------------
    // Tests
    // -------------------------------------------------------------------------
    task automatic test_reset();
        bit bad_out;
        bad_out = 1'b0;
        #1 reset_n_in = 1'b0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk_in);
            if (i % 2 == 0) bus.sclk_in = ~bus.sclk_in;
            bus.cs_n_in = (i % 3 == 0);
            bus.mosi_in = i[0];
            if (i > 0 && (bus.data_out !== 8'h00 || bus.data_valid_out !== 1'b0 ||
                          bus.miso_out !== 1'b0 || bus.tx_load_out !== 1'b0 ||
                          bus.overrun_out !== 1'b0 || bus.frame_err_out !== 1'b0))
                bad_out = 1'b1;
        end
        checks++;
        if (bad_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
        end
        bus.sclk_in = 1'b0;
        bus.cs_n_in = 1'b1;
        bus.mosi_in = 1'b0;
        @(negedge clk_in);
        reset_n_in = 1'b1;
        repeat (5) @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b0 || bus.data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: valid=%b data=%h, required valid=0 data=00",
                     bus.data_valid_out, bus.data_out);
        end
        checks++;
        if (bus.miso_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_miso: got %b, required 0", bus.miso_out);
        end
        checks++;
        if (tx_load_cnt != 0 || overrun_cnt != 0 || frame_err_cnt != 0) begin
            failures++;
            $display("FAIL reset_pulses: load=%0d ovr=%0d ferr=%0d, required 0 0 0",
                     tx_load_cnt, overrun_cnt, frame_err_cnt);
        end
    endtask

    task automatic test_single_byte();
        logic [7:0] m;
        logic       mb;
        int         l0;
        int         f0;
        l0 = tx_load_cnt;
        f0 = frame_err_cnt;
        bus.tx_data_in = 8'h3C;
        start_frame();
        shift_bits(8'hA5, 7, 1'b1, m);
        sclk_bit(1'b1, mb);             // 8th bit of 0xA5
        repeat (2) @(negedge clk_in);   // edge now synchronised and detected
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL single_latency_early: valid=%b, required 0", bus.data_valid_out);
        end
        @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 8'hA5) begin
            failures++;
            $display("FAIL single_data: valid=%b data=%h, required valid=1 data=a5",
                     bus.data_valid_out, bus.data_out);
        end
        checks++;
        if ({m[6:0], mb} !== 8'h3C) begin
            failures++;
            $display("FAIL single_miso: got %h, required 3c", {m[6:0], mb});
        end
        @(negedge clk_in);
        checks++;
        if (tx_load_cnt - l0 != 1) begin
            failures++;
            $display("FAIL single_load_start: got %0d pulses, required 1", tx_load_cnt - l0);
        end
        ack_word();
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL single_ack_clear: valid=%b, required 0", bus.data_valid_out);
        end
        bus.sclk_in = 1'b0;
        repeat (4) @(negedge clk_in);
        checks++;
        if (tx_load_cnt - l0 != 2) begin
            failures++;
            $display("FAIL single_reload: got %0d pulses, required 2", tx_load_cnt - l0);
        end
        end_frame();
        checks++;
        if (frame_err_cnt != f0) begin
            failures++;
            $display("FAIL single_no_ferr: got %0d pulses, required 0", frame_err_cnt - f0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        logic [7:0] m;
        int         l0;
        int         o0;
        int         f0;
        words[0] = 8'h01;
        words[1] = 8'h80;
        words[2] = 8'hFF;
        l0 = tx_load_cnt;
        o0 = overrun_cnt;
        f0 = frame_err_cnt;
        bus.tx_data_in = 8'h96;
        start_frame();
        for (int k = 0; k < 3; k++) begin
            shift_bits(words[k], 8, 1'b0, m);   // sclk left high
            checks++;
            if (bus.data_valid_out !== 1'b1 || bus.data_out !== words[k]) begin
                failures++;
                $display("FAIL b2b_word%0d: valid=%b data=%h, required valid=1 data=%h",
                         k, bus.data_valid_out, bus.data_out, words[k]);
            end
            checks++;
            if (m !== 8'h96) begin
                failures++;
                $display("FAIL b2b_miso%0d: got %h, required 96", k, m);
            end
            if (k == 2) begin
                // Loads that fed the three words: cs fall plus two reloads.
                checks++;
                if (tx_load_cnt - l0 != 3) begin
                    failures++;
                    $display("FAIL b2b_loads: got %0d pulses, required 3", tx_load_cnt - l0);
                end
            end
            ack_word();
            bus.sclk_in = 1'b0;
        end
        repeat (4) @(negedge clk_in);
        checks++;
        if (tx_load_cnt - l0 != 4) begin
            failures++;
            $display("FAIL b2b_final_reload: got %0d pulses, required 4", tx_load_cnt - l0);
        end
        end_frame();
        checks++;
        if (bus.data_valid_out !== 1'b0 || overrun_cnt != o0 || frame_err_cnt != f0) begin
            failures++;
            $display("FAIL b2b_tail: valid=%b ovr=%0d ferr=%0d, required 0 0 0",
                     bus.data_valid_out, overrun_cnt - o0, frame_err_cnt - f0);
        end
    endtask

    task automatic test_overrun();
        logic [7:0] m;
        int         o0;
        o0 = overrun_cnt;
        bus.tx_data_in = 8'h00;
        start_frame();
        shift_bits(8'h11, 8, 1'b1, m);
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
            failures++;
            $display("FAIL ovr_first: valid=%b data=%h, required valid=1 data=11",
                     bus.data_valid_out, bus.data_out);
        end
        shift_bits(8'h22, 8, 1'b1, m);
        repeat (2) @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 8'h11) begin
            failures++;
            $display("FAIL ovr_hold: valid=%b data=%h, required valid=1 data=11",
                     bus.data_valid_out, bus.data_out);
        end
        checks++;
        if (overrun_cnt - o0 != 1) begin
            failures++;
            $display("FAIL ovr_pulse: got %0d pulses, required 1", overrun_cnt - o0);
        end
        end_frame();
        ack_word();
        @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL ovr_ack: valid=%b, required 0", bus.data_valid_out);
        end
    endtask

    task automatic test_frame_error();
        logic [7:0] m;
        int         f0;
        f0 = frame_err_cnt;
        start_frame();
        shift_bits(8'hF8, 5, 1'b1, m);
        end_frame();
        checks++;
        if (frame_err_cnt - f0 != 1 || bus.data_valid_out !== 1'b0) begin
            failures++;
            $display("FAIL ferr_pulse: pulses=%0d valid=%b, required pulses=1 valid=0",
                     frame_err_cnt - f0, bus.data_valid_out);
        end
        start_frame();
        shift_bits(8'h5A, 8, 1'b1, m);
        repeat (2) @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 8'h5A) begin
            failures++;
            $display("FAIL ferr_next: valid=%b data=%h, required valid=1 data=5a",
                     bus.data_valid_out, bus.data_out);
        end
        end_frame();
        checks++;
        if (frame_err_cnt - f0 != 1) begin
            failures++;
            $display("FAIL ferr_clean_end: got %0d pulses, required 1", frame_err_cnt - f0);
        end
        ack_word();
    endtask

    task automatic test_async_reset();
        logic [7:0] m;
        int         l0;
        int         f0;
        bus.tx_data_in = 8'hE7;
        start_frame();
        shift_bits(8'hFF, 3, 1'b1, m);
        #3 reset_n_in = 1'b0;
        #1;
        checks++;
        if (bus.data_valid_out !== 1'b0 || bus.miso_out !== 1'b0 || bus.data_out !== 8'h00) begin
            failures++;
            $display("FAIL arst_idle: valid=%b miso=%b data=%h, required 0 0 00",
                     bus.data_valid_out, bus.miso_out, bus.data_out);
        end
        @(negedge clk_in);
        l0 = tx_load_cnt;
        f0 = frame_err_cnt;
        reset_n_in = 1'b1;              // cs_n still held low
        repeat (4) @(negedge clk_in);
        checks++;
        if (tx_load_cnt - l0 != 1) begin
            failures++;
            $display("FAIL arst_reload: got %0d pulses, required 1", tx_load_cnt - l0);
        end
        shift_bits(8'hC3, 8, 1'b1, m);
        repeat (2) @(negedge clk_in);
        checks++;
        if (bus.data_valid_out !== 1'b1 || bus.data_out !== 8'hC3) begin
            failures++;
            $display("FAIL arst_next: valid=%b data=%h, required valid=1 data=c3",
                     bus.data_valid_out, bus.data_out);
        end
        checks++;
        if (m !== 8'hE7) begin
            failures++;
            $display("FAIL arst_miso: got %h, required e7", m);
        end
        end_frame();
        checks++;
        if (frame_err_cnt != f0) begin
            failures++;
            $display("FAIL arst_no_ferr: got %0d pulses, required 0", frame_err_cnt - f0);
        end
        ack_word();
    endtask

    // -------------------------------------------------------------------------
    // Sequencer and watchdog
    // -------------------------------------------------------------------------
    initial begin
        bus.sclk_in     = 1'b0;
        bus.cs_n_in     = 1'b1;
        bus.mosi_in     = 1'b0;
        bus.data_ack_in = 1'b0;
        bus.tx_data_in  = 8'h00;

        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overrun();
        test_frame_error();
        test_async_reset();

        repeat (4) @(negedge clk_in);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
